// File: rtl/scan_sequencer_pkg.sv
// Shared state encoding and sizing for the 3-to-8 decoder scan sequencer.
package scan_sequencer_pkg;

    localparam int unsigned DWELL_W_DEF = 8;
    localparam int unsigned N_CHAN      = 8;
    localparam int unsigned CHAN_W      = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/scan_sequencer_next_chan_finder.sv
// Combinational channel search: next enabled channel above the current one,
// lowest enabled channel, and wrap / empty-mask flags.
module next_chan_finder
    import scan_sequencer_pkg::*;
(
    input  logic [CHAN_W-1:0] idx_i,
    input  logic [N_CHAN-1:0] mask_i,
    output logic [CHAN_W-1:0] next_o,
    output logic              wrap_o,
    output logic [CHAN_W-1:0] lowest_o,
    output logic              mask_empty_o
);

    // Descending scan so the smallest qualifying index is the last one written.
    always_comb begin
        next_o   = '0;
        lowest_o = '0;
        wrap_o   = 1'b1;
        for (int i = int'(N_CHAN) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_o = CHAN_W'(i);
                if (i > int'(idx_i)) begin
                    next_o = CHAN_W'(i);
                    wrap_o = 1'b0;
                end
            end
        end
    end

    assign mask_empty_o = ~|mask_i;

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer driving a 3-to-8 decoder: walks enabled channels in ascending
// order, holding each for dwell+1 cycles, in one-shot or continuous mode.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N_CHAN-1:0]  chan_mask,
    output logic               e,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               busy,
    output logic               done
);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [N_CHAN-1:0]   mask_q, mask_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [CHAN_W-1:0]   idx_q, idx_d;
    logic                e_q, e_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [N_CHAN-1:0]   find_mask;
    logic [CHAN_W-1:0]   next_idx;
    logic [CHAN_W-1:0]   lowest_idx;
    logic                wrap;
    logic                mask_empty;

    // In IDLE the search runs on the live mask so the first channel is known at start.
    assign find_mask = (state_q == IDLE) ? chan_mask : mask_q;

    next_chan_finder u_finder (
        .idx_i        (idx_q),
        .mask_i       (find_mask),
        .next_o       (next_idx),
        .wrap_o       (wrap),
        .lowest_o     (lowest_idx),
        .mask_empty_o (mask_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            dwell_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        e_d     = e_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                e_d    = 1'b0;
                idx_d  = '0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (start && !stop) begin
                    mode_d  = mode;
                    dwell_d = dwell;
                    mask_d  = chan_mask;
                    if (mask_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        e_d     = 1'b1;
                        idx_d   = lowest_idx;
                        cnt_d   = dwell;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    e_d     = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (!wrap) begin
                        idx_d = next_idx;
                        cnt_d = dwell_q;
                    end else if (mode_q) begin
                        idx_d = lowest_idx;
                        cnt_d = dwell_q;
                    end else begin
                        state_d = IDLE;
                        e_d     = 1'b0;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign e    = e_q;
    assign a    = idx_q[2];
    assign b    = idx_q[1];
    assign c    = idx_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Drives the 3-to-8 decoder stage: generates its enable `e` and select `a`,`b`,`c` (`a` = MSB).
- Steps through the eight decoder outputs in ascending order, skipping masked-off channels.
- Each channel is held for a programmable dwell time.
- Supports one-shot and continuous scanning; used for LED/digit scanning and channel-strobe sequencing.

Parameters:
DWELL_W, 8, width of dwell count input and internal dwell counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin scan; sampled only in IDLE
stop  input  1  abort scan; return to IDLE next cycle
mode  input  1  0 = one-shot (single pass), 1 = continuous
dwell  input  DWELL_W  hold count per channel; channel held dwell+1 cycles
chan_mask  input  8  bit i = 1 enables channel i
e  output  1  decoder enable, registered
a  output  1  channel index bit 2, registered
b  output  1  channel index bit 1, registered
c  output  1  channel index bit 0, registered
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at end of one-shot pass or empty-mask start

Behaviour:
- Reset (rst_n low, async): state = IDLE. Outputs `e`, `a`, `b`, `c`, `busy`, `done` all 0. Dwell counter = 0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, RUN.
- IDLE:
  - e = 0; {a,b,c} holds 000; busy = 0.
  - On start = 1 and stop = 0, latch `mode`, `dwell` and `chan_mask`.
  - Latched mask nonzero: next cycle state = RUN, e = 1, {a,b,c} = lowest enabled channel, counter = dwell, busy = 1.
  - Latched mask == 0: next cycle done = 1 for one cycle; stay in IDLE.
- RUN:
  - e = 1. The counter decrements each cycle.
  - When the counter == 0 (last cycle of the channel), advance next cycle to the next enabled channel above the current one and reload the counter from latched dwell.
  - No enabled channel above the current one (wrap):
    - mode 1: go to the lowest enabled channel.
    - mode 0: next cycle state = IDLE, e = 0, {a,b,c} = 000, busy = 0, done = 1 for one cycle.
  - A single enabled channel in mode 1 stays on that channel indefinitely, and the counter keeps reloading.
- Timing:
  - Channel hold = dwell+1 cycles, measured as e = 1 with a constant index.
  - First channel appears the cycle after start is sampled.
  - dwell = 0 gives one cycle per channel.
- stop:
  - Any state: next cycle state = IDLE, e = 0, {a,b,c} = 000, busy = 0, done = 0.
  - Simultaneous start and stop: stop wins.
- start while in RUN is ignored.
- Input changes during RUN have no effect: mask, dwell and mode are used only as latched at start.
- A done pulse and a new start are independent. start sampled in the cycle done = 1 (state IDLE) is accepted.
- Reset asserted mid-scan forces the reset values immediately (asynchronous), with no done pulse.

Decomposition:
- Shared include file: state encodings (IDLE = 1'b0, RUN = 1'b1) as localparams/defines, and the default DWELL_W.
- One sub-module: next_chan_finder. It is combinational.
  - Inputs: current index (3 b), mask (8 b).
  - Outputs: next-higher enabled index, wrap flag (no higher enabled channel), lowest enabled index, mask_empty flag.
- The sequencer instantiates it once.

Test Plan:
- Full pass, one-shot: mask 8'hFF, dwell 2, mode 0, start pulse -> e = 1 for 24 cycles, {a,b,c} = 0..7 with 3 cycles each; then e = 0 and a done pulse on cycle 25 after start.
- Sparse, continuous: mask 8'b1010_0010, dwell 0, mode 1 -> index sequence 1,5,7,1,5,7,... one cycle each; busy stays 1; no done.
- Stop mid-scan: mask 8'hFF, dwell 3, stop asserted in channel 4 -> next cycle e = 0, {a,b,c} = 000, busy = 0, no done; a subsequent start restarts at channel 0.
- Empty mask: mask 8'h00, start -> single done pulse next cycle; e and busy stay 0.
- Ignored inputs: start and stop together -> no scan. Start while running -> sequence unchanged. Mask changed mid-scan -> latched mask still used.
- Reset mid-scan: rst_n low asynchronously during channel 3 -> all outputs 0 before the next clock edge. After release, IDLE until start.
